// File: rtl/stage_mem_if.sv
// stage_mem_if: EX/MEM inputs, stall back to the pipeline and the MEM/WB register outputs.
interface stage_mem_if;
    logic       valid_MEM;
    logic       RegWrite_MEM;
    logic       ResultSrc_MEM;
    logic       MemWrite_MEM;
    logic [7:0] alu_result_MEM;
    logic [7:0] store_data_MEM;
    logic [2:0] rd_MEM;
    logic       stall_MEM;
    logic       valid_WB;
    logic       RegWrite_WB;
    logic       ResultSrc_WB;
    logic [7:0] alu_result_WB;
    logic [7:0] mem_data_WB;
    logic [2:0] rd_WB;
    modport master (
        output valid_MEM, RegWrite_MEM, ResultSrc_MEM, MemWrite_MEM, alu_result_MEM, store_data_MEM, rd_MEM,
        input  stall_MEM, valid_WB, RegWrite_WB, ResultSrc_WB, alu_result_WB, mem_data_WB, rd_WB
    );
    modport slave (
        input  valid_MEM, RegWrite_MEM, ResultSrc_MEM, MemWrite_MEM, alu_result_MEM, store_data_MEM, rd_MEM,
        output stall_MEM, valid_WB, RegWrite_WB, ResultSrc_WB, alu_result_WB, mem_data_WB, rd_WB
    );
endinterface

// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage owning the byte-wide data memory, with a
// MEM_LAT-cycle load/store latency that stalls upstream while an access is in flight.
module stage_mem #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 3
) (
    input logic        clk,
    input logic        reset,
    stage_mem_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                st_q, ld_q, rw_q;
    logic [7:0]          alu_q, data_q;
    logic [2:0]          rd_q;
    logic                valid_wb_q, rw_wb_q, rs_wb_q;
    logic [7:0]          alu_wb_q, mem_wb_q;
    logic [2:0]          rd_wb_q;
    logic [7:0]          mem_q [0:(1<<ADDR_W)-1];
    logic                acc, memop, start, commit, s_st, s_ld, s_rw;
    logic [7:0]          s_alu, s_data;
    logic [2:0]          s_rd;
    logic [ADDR_W-1:0]   addr;
    // The op being retired comes from the latch while in ACCESS, straight from EX/MEM otherwise.
    always_comb begin
        acc           = state_q == ACCESS;
        memop         = bus.valid_MEM & (bus.MemWrite_MEM | bus.ResultSrc_MEM);
        start         = ~acc & memop & (MEM_LAT > 1);
        commit        = acc ? (cnt_q == CW'(1)) : (bus.valid_MEM & ~start);
        s_st          = acc ? st_q   : bus.MemWrite_MEM;
        s_ld          = acc ? ld_q   : bus.ResultSrc_MEM & ~bus.MemWrite_MEM;
        s_rw          = acc ? rw_q   : bus.RegWrite_MEM;
        s_alu         = acc ? alu_q  : bus.alu_result_MEM;
        s_data        = acc ? data_q : bus.store_data_MEM;
        s_rd          = acc ? rd_q   : bus.rd_MEM;
        addr          = s_alu[ADDR_W-1:0];
        bus.stall_MEM = acc ? (cnt_q > CW'(1)) : start;
        state_d       = start ? ACCESS : (acc && commit) ? IDLE : state_q;
        cnt_d         = start ? CW'(MEM_LAT - 1) : acc ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            st_q       <= 1'b0;
            ld_q       <= 1'b0;
            rw_q       <= 1'b0;
            alu_q      <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            valid_wb_q <= 1'b0;
            rw_wb_q    <= 1'b0;
            rs_wb_q    <= 1'b0;
            alu_wb_q   <= '0;
            mem_wb_q   <= '0;
            rd_wb_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (start) begin
                st_q   <= bus.MemWrite_MEM;
                ld_q   <= bus.ResultSrc_MEM & ~bus.MemWrite_MEM;
                rw_q   <= bus.RegWrite_MEM;
                alu_q  <= bus.alu_result_MEM;
                data_q <= bus.store_data_MEM;
                rd_q   <= bus.rd_MEM;
            end
            valid_wb_q <= commit;
            rw_wb_q    <= commit & s_rw & ~s_st;
            rs_wb_q    <= commit & s_ld;
            alu_wb_q   <= commit ? s_alu : '0;
            mem_wb_q   <= (commit & s_ld) ? mem_q[addr] : '0;
            rd_wb_q    <= commit ? s_rd : '0;
        end
    end
    // Memory is never cleared; a store interrupted by reset is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset && commit && s_st) mem_q[addr] <= s_data;
    end
    assign bus.valid_WB      = valid_wb_q;
    assign bus.RegWrite_WB   = rw_wb_q;
    assign bus.ResultSrc_WB  = rs_wb_q;
    assign bus.alu_result_WB = alu_wb_q;
    assign bus.mem_data_WB   = mem_wb_q;
    assign bus.rd_WB         = rd_wb_q;
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: random and directed ops on stage_mem (8-bit/3-cycle and 4-bit/1-cycle)
// against a transaction-level model of latency, stall and memory contents.
module tb_stage_mem;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [7:0] ref1 [256];
    logic [7:0] ref2 [16];
    logic [21:0] wb1, wb2;
    stage_mem_if b1();
    stage_mem_if b2();
    stage_mem #(.ADDR_W(8), .MEM_LAT(3)) dut  (.clk(clk), .reset(reset), .bus(b1));
    stage_mem #(.ADDR_W(4), .MEM_LAT(1)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    always #5 clk = ~clk;
    assign wb1 = {b1.valid_WB, b1.RegWrite_WB, b1.ResultSrc_WB, b1.alu_result_WB, b1.mem_data_WB, b1.rd_WB};
    assign wb2 = {b2.valid_WB, b2.RegWrite_WB, b2.ResultSrc_WB, b2.alu_result_WB, b2.mem_data_WB, b2.rd_WB};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic drv1(input logic v, rw, rs, mw, input logic [7:0] alu, sd, input logic [2:0] rd);
        b1.valid_MEM = v; b1.RegWrite_MEM = rw; b1.ResultSrc_MEM = rs; b1.MemWrite_MEM = mw;
        b1.alu_result_MEM = alu; b1.store_data_MEM = sd; b1.rd_MEM = rd;
    endtask
    task automatic drv2(input logic v, rw, rs, mw, input logic [7:0] alu, sd, input logic [2:0] rd);
        b2.valid_MEM = v; b2.RegWrite_MEM = rw; b2.ResultSrc_MEM = rs; b2.MemWrite_MEM = mw;
        b2.alu_result_MEM = alu; b2.store_data_MEM = sd; b2.rd_MEM = rd;
    endtask
    // Present one op, scramble inputs while it is in flight, and check stall and MEM/WB each cycle.
    task automatic issue1(input logic v, rw, rs, mw, input logic [7:0] alu, sd, input logic [2:0] rd);
        logic [21:0] exp;
        int lat;
        lat = (v & (mw | rs)) ? 3 : 1;
        exp = {v, v & rw & ~mw, v & rs & ~mw, v ? alu : 8'h0, (v & rs & ~mw) ? ref1[alu] : 8'h0, v ? rd : 3'h0};
        if (v & mw) ref1[alu] = sd;
        drv1(v, rw, rs, mw, alu, sd, rd);
        for (int k = 0; k < lat; k++) begin
            if (k > 0) drv1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
            #1 chk("stall", 32'(b1.stall_MEM), 32'(k < lat - 1));
            @(posedge clk); #1;
            chk(k == lat - 1 ? "wb" : "bubble", 32'(wb1), k == lat - 1 ? 32'(exp) : 32'h0);
        end
    endtask
    task automatic issue2(input logic v, rw, rs, mw, input logic [7:0] alu, sd, input logic [2:0] rd);
        logic [21:0] exp;
        exp = {v, v & rw & ~mw, v & rs & ~mw, v ? alu : 8'h0, (v & rs & ~mw) ? ref2[alu[3:0]] : 8'h0, v ? rd : 3'h0};
        if (v & mw) ref2[alu[3:0]] = sd;
        drv2(v, rw, rs, mw, alu, sd, rd);
        #1 chk("stall2", 32'(b2.stall_MEM), 32'h0);
        @(posedge clk); #1;
        chk("wb2", 32'(wb2), 32'(exp));
    endtask
    initial begin
        reset = 1'b1;
        drv1(0, 0, 0, 0, 8'h0, 8'h0, 3'h0);
        drv2(0, 0, 0, 0, 8'h0, 8'h0, 3'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb1", 32'(wb1), 32'h0);
        chk("rst_wb2", 32'(wb2), 32'h0);
        chk("rst_stall", 32'(b1.stall_MEM), 32'h0);
        reset = 1'b0;
        issue1(1, 1, 0, 0, 8'h5A, 8'h00, 3'd2);
        for (int i = 0; i < 256; i++) issue1(1, 0, 0, 1, 8'(i), 8'($urandom), 3'($urandom));
        issue1(1, 1, 0, 1, 8'h10, 8'hC3, 3'd1);
        issue1(1, 1, 1, 0, 8'h10, 8'h00, 3'd5);
        issue1(1, 1, 1, 1, 8'h40, 8'h9E, 3'd3);
        issue1(1, 1, 1, 0, 8'h40, 8'h00, 3'd6);
        issue1(0, 1, 1, 1, 8'hFF, 8'hFF, 3'd7);
        issue1(0, 1, 0, 0, 8'h33, 8'h00, 3'd1);
        issue1(1, 0, 0, 1, 8'h20, 8'h11, 3'd0);
        drv1(1, 0, 0, 1, 8'h20, 8'h77, 3'd0);
        #1 chk("rst_mid_s0", 32'(b1.stall_MEM), 32'h1);
        @(posedge clk); #1;
        chk("rst_mid_s1", 32'(b1.stall_MEM), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        drv1(0, 0, 0, 0, 8'h0, 8'h0, 3'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_wb", 32'(wb1), 32'h0);
        #1 chk("rst_mid_stall", 32'(b1.stall_MEM), 32'h0);
        issue1(1, 1, 0, 0, 8'hA7, 8'h00, 3'd4);
        issue1(1, 1, 1, 0, 8'h20, 8'h00, 3'd5);
        for (int i = 0; i < 300; i++)
            issue1(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
        drv1(0, 0, 0, 0, 8'h0, 8'h0, 3'h0);
        for (int i = 0; i < 16; i++) issue2(1, 0, 0, 1, 8'(i), 8'($urandom), 3'($urandom));
        issue2(1, 1, 0, 1, 8'h00, 8'hA5, 3'd1);
        issue2(1, 1, 1, 0, 8'h10, 8'h00, 3'd4);
        issue2(1, 0, 0, 1, 8'h13, 8'h3C, 3'd2);
        issue2(1, 1, 1, 0, 8'hF3, 8'h00, 3'd7);
        for (int i = 0; i < 60; i++)
            issue2(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
